// File: rtl/pmod_arbiter.sv
// Round-robin arbiter that shares one 8-bit PMOD port and the activity LED among N_REQ requesters.
// The dwell time is bounded by prescaler ticks, and a guard gap drives IDLE_VAL between owners.
module pmod_arbiter #(
    parameter int         N_REQ      = 4,
    parameter int         DIV        = 100,
    parameter int         HOLD_TICKS = 16,
    parameter logic [7:0] IDLE_VAL   = 8'h00
) (
    input  logic               CLK_100,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] DATA,
    output logic [N_REQ-1:0]   GNT,
    output logic [7:0]         PMOD_A,
    output logic               LED_A,
    output logic               BUSY
);

    // state | meaning
    // IDLE  | no owner, arbitrate immediately on any REQ
    // GRANT | owner drives PMOD_A, dwell counts prescaler ticks
    // GAP   | port idle until the next tick, then re-arbitrate
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DIV);
    localparam int DWL_W = $clog2(HOLD_TICKS) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [DWL_W-1:0] DWL_MAX  = DWL_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_WRAP   = (IDX_W + 1)'(N_REQ);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWL_W-1:0]   dwell_q;
    logic [IDX_W-1:0]   owner_q, last_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [7:0]         pmod_q;
    logic               led_q, busy_q;

    logic               tick;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic [IDX_W:0]     rr_sum;
    logic               others_req;
    logic               owner_drop;
    logic               timeout;
    logic [7:0]         data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign data_arr[i] = DATA[8*i +: 8];
    end

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Search from last+1 upward so the previous owner ends up with lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_sum = {1'b0, last_q} + (IDX_W + 1)'(k);
            if (rr_sum >= N_WRAP) begin
                rr_sum = rr_sum - N_WRAP;
            end
            if (!win_found && REQ[rr_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    assign win_oh     = N_REQ'(1) << win_idx;
    assign others_req = |(REQ & ~gnt_q);
    assign owner_drop = !REQ[owner_q];
    assign timeout    = tick && (dwell_q == DWL_MAX) && others_req;

    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            dwell_q <= '0;
            gnt_q   <= '0;
            pmod_q  <= IDLE_VAL;
            led_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            pmod_q <= (state_q == S_GRANT) ? data_arr[owner_q] : IDLE_VAL;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_q <= S_GRANT;
                        owner_q <= win_idx;
                        gnt_q   <= win_oh;
                        dwell_q <= '0;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // A drop coinciding with a timeout takes the release path; the outcome is identical.
                    if (owner_drop || timeout) begin
                        state_q <= S_GAP;
                        last_q  <= owner_q;
                        gnt_q   <= '0;
                        led_q   <= 1'b1;
                    end else if (tick) begin
                        dwell_q <= (dwell_q == DWL_MAX) ? '0 : dwell_q + DWL_W'(1);
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (win_found) begin
                            state_q <= S_GRANT;
                            owner_q <= win_idx;
                            gnt_q   <= win_oh;
                            dwell_q <= '0;
                            led_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    led_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT    = gnt_q;
    assign PMOD_A = pmod_q;
    assign LED_A  = led_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_pmod_arbiter.sv
// Directed bench for pmod_arbiter with N_REQ=4, DIV=4, HOLD_TICKS=3 and IDLE_VAL=0.
module tb_pmod_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  pmod;
    logic        led;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pmod_arbiter #(
        .N_REQ(4), .DIV(4), .HOLD_TICKS(3), .IDLE_VAL(8'h00)
    ) dut (
        .CLK_100(clk), .RST_N(rst_n), .REQ(req), .DATA(data),
        .GNT(gnt), .PMOD_A(pmod), .LED_A(led), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [3:0] g);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 4; i++) if (g[i]) v = data[8*i +: 8];
        return v;
    endfunction

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic reset_pulse(input logic [3:0] r);
        @(negedge clk);
        req   = r;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_ord [5];
    logic [3:0] gv;
    int gz, pz, gl, bad, c;

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b0100;
        exp_ord[3] = 4'b1000; exp_ord[4] = 4'b0001;

        // 1: reset values, then first grant after release
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_pmod", 32'(pmod), 32'h00);
        chk("rst_led", 32'(led), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        req   = 4'b0101;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_gnt", 32'(gnt), 32'b0001);
        chk("rel_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        wait_idle();

        // 2: single requester keeps the port with no timeout
        req = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("single_gnt", 32'(gnt), 32'b0100);
            chk("single_led", 32'(led), 32'd0);
            chk("single_pmod", 32'(pmod), (i == 0) ? 32'h00 : 32'hA5);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("drop_gnt", 32'(gnt), 32'd0);
        chk("drop_pmod_lag", 32'(pmod), 32'hA5);
        @(negedge clk);
        chk("drop_pmod", 32'(pmod), 32'h00);
        wait_idle();

        // 3: timeout and rotation with everybody requesting
        reset_pulse(4'b1111);
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            gz = 0;
            pz = 0;
            while (gnt == 4'b0000 && gz < 40) begin
                if (pmod == 8'h00) pz++;
                gz++;
                @(negedge clk);
            end
            gv = gnt;
            chk("rot_order", 32'(gv), 32'(exp_ord[n]));
            gl  = 0;
            bad = 0;
            while (gnt == gv && gl < 40) begin
                if (gl == 0) begin
                    if (pmod == 8'h00) pz++;
                end else if (pmod != lane(gv)) begin
                    bad++;
                end
                gl++;
                @(negedge clk);
            end
            chk("rot_len", 32'(gl), (n == 0) ? 32'd11 : 32'd12);
            chk("rot_pmod", 32'(bad), 32'd0);
            if (n > 0) begin
                chk("rot_gap", 32'(gz), 32'd4);
                chk("rot_gap_pmod", 32'(pz), 32'd4);
            end
        end
        req = 4'b0000;
        wait_idle();

        // 4: a requester that just released gets lowest priority
        req = 4'b0010;
        @(negedge clk);
        chk("fair_own", 32'(gnt), 32'b0010);
        req = 4'b0001;
        @(negedge clk);
        chk("fair_gap_gnt", 32'(gnt), 32'd0);
        chk("fair_gap_busy", 32'(busy), 32'd1);
        req = 4'b0011;
        c = 0;
        while (gnt == 4'b0000 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("fair_next", 32'(gnt), 32'b0001);
        req = 4'b0000;
        wait_idle();

        // 5: owner drops in the same tick cycle as its timeout
        reset_pulse(4'b1111);
        repeat (11) @(negedge clk);
        chk("sim_own", 32'(gnt), 32'b0001);
        req = 4'b1110;
        @(negedge clk);
        chk("sim_gnt", 32'(gnt), 32'd0);
        gz = 0;
        while (gnt == 4'b0000 && gz < 40) begin
            gz++;
            @(negedge clk);
        end
        chk("sim_gap", 32'(gz), 32'd4);
        chk("sim_next", 32'(gnt), 32'b0010);
        req = 4'b0000;
        wait_idle();

        // 6: asynchronous reset in the middle of a grant
        req = 4'b1000;
        @(negedge clk);
        chk("mid_own", 32'(gnt), 32'b1000);
        @(negedge clk);
        chk("mid_pmod", 32'(pmod), 32'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_pmod_clr", 32'(pmod), 32'h00);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_led", 32'(led), 32'd1);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after", 32'(gnt), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
